// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg (package)
// Description : Shared types and constants for the instruction-fetch slice:
//               fetch FSM state encoding, default bus widths and the halt
//               instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int          c_ADDR_W    = 8;
    localparam int          c_DATA_W    = 16;
    localparam logic [15:0] c_HALT_WORD = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if (interface)
// Description : Bundles the ROM port, the decode valid/ready handshake and
//               the redirect request of the fetch sequencer.
//   rom_addr    : ROM address (fetch -> ROM)
//   rom_q       : ROM read data (ROM -> fetch)
//   instr       : instruction to decode
//   instr_pc    : address of instr
//   instr_valid : instr/instr_pc valid
//   instr_ready : decode accepts on valid && ready at a rising edge
//   redirect    : branch/jump taken
//   redirect_pc : redirect target
//   Modports: master = fetch_ctrl side, slave = ROM/decode/branch side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output rom_addr, instr, instr_pc, instr_valid,
        input  rom_q, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid,
        output rom_q, instr_ready, redirect, redirect_pc
    );
endinterface : fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Program counter register. Load has priority over increment;
//               increment wraps naturally at the top of the address space.
//   clk, rst   : clock, asynchronous active-high reset (pc -> START_PC)
//   load_i     : load load_pc_i (redirect / restart)
//   load_pc_i  : value to load
//   inc_i      : advance pc by one
//   pc_o       : current pc (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load_i,
    input  wire logic [ADDR_W-1:0] load_pc_i,
    input  wire logic              inc_i,
    output logic      [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= START_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : fetch_pc
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the PC, drives the ROM
//               address, waits out the ROM read latency and hands each
//               instruction to decode over a valid/ready handshake. Handles
//               redirects, start/restart and halting on HALT_WORD.
//   clk, rst      : clock, asynchronous active-high reset
//   run_i         : start/restart pulse (sampled in IDLE and HALT)
//   bus_if        : fetch_ctrl_if.master (ROM, decode, redirect)
//   halted_o      : fetch stopped on HALT_WORD
//   retired_cnt_o : accepted-instruction count
// Build option : FETCH_RETIRE_CNT_EN - when defined, retired_cnt_o counts
//               every accept (wrapping); otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import proc_pkg::*;
#(
    parameter int                ADDR_W    = c_ADDR_W,
    parameter int                DATA_W    = c_DATA_W,
    parameter int                ROM_LAT   = 1,
    parameter logic [ADDR_W-1:0] START_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(c_HALT_WORD)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        run_i,
    fetch_ctrl_if.master     bus_if,
    output logic             halted_o,
    output logic [15:0]      retired_cnt_o
);

    // ROM_LAT is limited to 1..3, so two bits always hold the wait count.
    localparam logic [1:0] c_LAT = 2'(ROM_LAT);

    fetch_state_t      state_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              valid_q;
    logic              halted_q;
    logic [ADDR_W-1:0] w_pc;

    logic              w_accept;
    logic              w_redirect;
    logic              w_restart;
    logic              w_pc_load;
    logic [ADDR_W-1:0] w_pc_load_val;
    logic              w_pc_inc;

    assign w_accept   = (state_q == ST_HOLD) && valid_q && bus_if.instr_ready;
    assign w_redirect = bus_if.redirect &&
                        ((state_q == ST_WAIT) || (state_q == ST_HOLD));
    assign w_restart  = (state_q == ST_HALT) && run_i;

    // Redirect wins over restart/increment; a redirect coincident with an
    // accept still lets the accept retire, but the pc follows the redirect.
    always_comb begin
        w_pc_load     = 1'b0;
        w_pc_load_val = bus_if.redirect_pc;
        w_pc_inc      = 1'b0;
        if (w_redirect) begin
            w_pc_load     = 1'b1;
            w_pc_load_val = bus_if.redirect_pc;
        end else if (w_restart) begin
            w_pc_load     = 1'b1;
            w_pc_load_val = START_PC;
        end else if (w_accept && (instr_q != HALT_WORD)) begin
            w_pc_inc      = 1'b1;
        end
    end

    // The pc register doubles as the registered ROM address.
    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .START_PC (START_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_pc_load),
        .load_pc_i (w_pc_load_val),
        .inc_i     (w_pc_inc),
        .pc_o      (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_i) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= 2'd0;
                    end
                end
                ST_WAIT: begin
                    if (w_redirect) begin
                        cnt_q   <= 2'd0;
                        valid_q <= 1'b0;
                    end else if (cnt_q == c_LAT) begin
                        // First edge after the address settles is the ROM
                        // sample; data is usable ROM_LAT edges later.
                        instr_q    <= bus_if.rom_q;
                        instr_pc_q <= w_pc;
                        valid_q    <= 1'b1;
                        state_q    <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_redirect) begin
                        valid_q <= 1'b0;
                        cnt_q   <= 2'd0;
                        state_q <= ST_WAIT;
                    end else if (w_accept) begin
                        valid_q <= 1'b0;
                        cnt_q   <= 2'd0;
                        if (instr_q == HALT_WORD) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            state_q  <= ST_WAIT;
                        end
                    end
                end
                ST_HALT: begin
                    if (run_i) begin
                        halted_q <= 1'b0;
                        cnt_q    <= 2'd0;
                        state_q  <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    logic [15:0] retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 16'h0000;
        end else if (w_accept) begin
            retired_q <= retired_q + 16'h0001;
        end
    end

    assign retired_cnt_o = retired_q;
`else
    assign retired_cnt_o = 16'h0000;
`endif

    assign bus_if.rom_addr    = w_pc;
    assign bus_if.instr       = instr_q;
    assign bus_if.instr_pc    = instr_pc_q;
    assign bus_if.instr_valid = valid_q;
    assign halted_o           = halted_q;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. Directed scenarios
//               (basic fetch, backpressure, redirect, wrap, restart, reset)
//               followed by a randomized run checked against an
//               architectural model (pc, halted, retired count and the
//               cycles elapsed since the last fetch was launched).
// Build option : FETCH_RETIRE_CNT_EN selects the retired-count expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import proc_pkg::*;

    localparam int          L   = 1;
    localparam logic [7:0]  SPC = 8'h00;
    localparam logic [15:0] HW  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        halted;
    logic [15:0] retired;

    fetch_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    fetch_ctrl #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .ROM_LAT   (L),
        .START_PC  (SPC),
        .HALT_WORD (HW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run),
        .bus_if        (bus),
        .halted_o      (halted),
        .retired_cnt_o (retired)
    );

    always #5 clk = ~clk;

    // ROM model: address sampled at each edge, data out L edges later.
    logic [15:0] mem      [256];
    logic [15:0] rom_pipe [L];

    always @(posedge clk) begin
        rom_pipe[0] <= mem[bus.rom_addr];
        for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_q = rom_pipe[L-1];

    int n_cmp = 0;
    int n_err = 0;
    int m_pc  = 0;
    int m_ret = 0;
    bit m_halt = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ret(input string tag);
`ifdef FETCH_RETIRE_CNT_EN
        chk(tag, {16'h0, retired}, m_ret & 32'hFFFF);
`else
        chk(tag, {16'h0, retired}, 32'h0);
`endif
    endtask

    // Called right after the edge that launched a fetch.
    task automatic wait_valid(input string tag);
        int lat = 0;
        while (bus.instr_valid !== 1'b1 && lat < 20) begin
            cyc();
            lat++;
        end
        chk({tag, "_lat"}, lat, L + 1);
    endtask

    // Expects instr_ready=1; checks one instruction and its accept.
    task automatic fetch_one(input string tag);
        wait_valid(tag);
        chk({tag, "_instr"}, {16'h0, bus.instr}, {16'h0, mem[m_pc]});
        chk({tag, "_pc"}, {24'h0, bus.instr_pc}, m_pc);
        cyc();
        m_ret++;
        if (mem[m_pc] == HW) m_halt = 1'b1;
        else                 m_pc = (m_pc + 1) % 256;
        chk({tag, "_vfall"}, {31'h0, bus.instr_valid}, 0);
        chk({tag, "_halted"}, {31'h0, halted}, {31'h0, m_halt});
        chk({tag, "_addr"}, {24'h0, bus.rom_addr}, m_pc);
        chk_ret({tag, "_ret"});
    endtask

    task automatic restart(input string tag);
        run = 1'b1;
        cyc();
        run = 1'b0;
        m_pc   = SPC;
        m_halt = 1'b0;
        chk({tag, "_halted0"}, {31'h0, halted}, 0);
    endtask

    task automatic do_redirect(input logic [7:0] tgt);
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        cyc();
        bus.redirect = 1'b0;
        m_pc = tgt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   since;
        bit   acc;
        bit   m_valid;
        logic rdy, rdr, rn;
        logic [7:0] tgt;

        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom_range(1, 16'hFFFF));
        mem[8'h00] = 16'hC30A;
        mem[8'h01] = 16'hC4F2;
        mem[8'h02] = 16'h0000;
        mem[8'h0C] = 16'h990F;
        mem[8'h0D] = 16'h0000;
        mem[8'hFF] = 16'h1234;

        rst = 1'b1; run = 1'b0;
        bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 8'h00;
        repeat (2) cyc();
        chk("rst_addr",   {24'h0, bus.rom_addr}, 0);
        chk("rst_instr",  {16'h0, bus.instr}, 0);
        chk("rst_ipc",    {24'h0, bus.instr_pc}, 0);
        chk("rst_valid",  {31'h0, bus.instr_valid}, 0);
        chk("rst_halted", {31'h0, halted}, 0);
        chk_ret("rst_ret");
        rst = 1'b0;
        repeat (3) begin
            cyc();
            chk("idle_valid", {31'h0, bus.instr_valid}, 0);
        end

        // Basic fetch through to the halt word.
        bus.instr_ready = 1'b1;
        restart("b");
        fetch_one("b0");
        fetch_one("b1");
        fetch_one("b2");
        chk("b_halted", {31'h0, halted}, 1);
        chk("b_haltaddr", {24'h0, bus.rom_addr}, 2);
        chk_ret("b_ret3");
        repeat (3) begin
            cyc();
            chk("halt_valid", {31'h0, bus.instr_valid}, 0);
        end

        // Backpressure on the second instruction.
        restart("bp");
        fetch_one("bp0");
        bus.instr_ready = 1'b0;
        wait_valid("bp1");
        for (int k = 0; k < 5; k++) begin
            chk("bp_instr", {16'h0, bus.instr}, 32'hC4F2);
            chk("bp_pc",    {24'h0, bus.instr_pc}, 1);
            chk("bp_valid", {31'h0, bus.instr_valid}, 1);
            chk("bp_addr",  {24'h0, bus.rom_addr}, 1);
            cyc();
        end
        bus.instr_ready = 1'b1;
        // Valid is already up, so the lat check inside sees zero extra waits;
        // account for it by accepting directly.
        chk("bp_instr2", {16'h0, bus.instr}, 32'hC4F2);
        cyc();
        m_ret++; m_pc = 2;
        chk("bp_addr2", {24'h0, bus.rom_addr}, 2);
        fetch_one("bp2");

        // Redirect while holding C30A.
        bus.instr_ready = 1'b0;
        restart("rd");
        wait_valid("rd0");
        do_redirect(8'h0C);
        chk("rd_vfall", {31'h0, bus.instr_valid}, 0);
        chk("rd_addr",  {24'h0, bus.rom_addr}, 32'h0C);
        chk_ret("rd_ret");
        bus.instr_ready = 1'b1;
        fetch_one("rd1");
        fetch_one("rd2");

        // Redirect coincident with the accept of C30A.
        bus.instr_ready = 1'b0;
        restart("ra");
        wait_valid("ra0");
        bus.instr_ready = 1'b1;
        do_redirect(8'h0C);
        m_ret++;
        chk("ra_vfall",  {31'h0, bus.instr_valid}, 0);
        chk("ra_addr",   {24'h0, bus.rom_addr}, 32'h0C);
        chk("ra_halted", {31'h0, halted}, 0);
        chk_ret("ra_ret");
        fetch_one("ra1");
        fetch_one("ra2");

        // PC wrap from FF to 00.
        bus.instr_ready = 1'b0;
        restart("wr");
        wait_valid("wr0");
        do_redirect(8'hFF);
        bus.instr_ready = 1'b1;
        fetch_one("wrFF");
        fetch_one("wr00");
        fetch_one("wr01");
        fetch_one("wr02");

        // Reset while waiting on pc 05.
        bus.instr_ready = 1'b0;
        restart("rs");
        wait_valid("rs0");
        do_redirect(8'h05);
        chk("rs_addr5", {24'h0, bus.rom_addr}, 5);
        rst = 1'b1;
        #1;
        chk("rs_addr",   {24'h0, bus.rom_addr}, 0);
        chk("rs_instr",  {16'h0, bus.instr}, 0);
        chk("rs_ipc",    {24'h0, bus.instr_pc}, 0);
        chk("rs_valid",  {31'h0, bus.instr_valid}, 0);
        chk("rs_halted", {31'h0, halted}, 0);
        m_ret = 0; m_pc = SPC; m_halt = 1'b0;
        chk_ret("rs_ret");
        cyc();
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (8) begin
            cyc();
            chk("rs_novalid", {31'h0, bus.instr_valid}, 0);
        end
        restart("rs2");
        fetch_one("rs2a");
        fetch_one("rs2b");
        fetch_one("rs2c");

        // Randomized run against the architectural model.
        since = 0;
        for (int c = 0; c < 400; c++) begin
            rn  = ($urandom_range(0, 3) == 0);
            rdy = 1'($urandom_range(0, 1));
            rdr = ($urandom_range(0, 7) == 0);
            tgt = 8'($urandom_range(0, 255));
            run = rn; bus.instr_ready = rdy; bus.redirect = rdr; bus.redirect_pc = tgt;
            m_valid = !m_halt && (since >= L + 1);
            acc = m_valid && rdy;
            cyc();
            if (m_halt) begin
                if (rn) begin m_halt = 1'b0; m_pc = SPC; since = 0; end
            end else begin
                if (acc) m_ret++;
                if (rdr) begin
                    m_pc = tgt; since = 0;
                end else if (acc) begin
                    if (mem[m_pc] == HW) m_halt = 1'b1;
                    else begin m_pc = (m_pc + 1) % 256; since = 0; end
                end else begin
                    since++;
                end
            end
            chk("rnd_addr",   {24'h0, bus.rom_addr}, m_pc);
            chk("rnd_halted", {31'h0, halted}, {31'h0, m_halt});
            chk("rnd_valid",  {31'h0, bus.instr_valid},
                {31'h0, (!m_halt && since >= L + 1)});
            if (!m_halt && since >= L + 1) begin
                chk("rnd_instr", {16'h0, bus.instr}, {16'h0, mem[m_pc]});
                chk("rnd_ipc",   {24'h0, bus.instr_pc}, m_pc);
            end
            chk_ret("rnd_ret");
        end
        run = 1'b0; bus.redirect = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the processor's instruction ROM and the decode stage.
- Owns the program counter (PC) and drives the ROM address.
- Absorbs the ROM's registered read latency and presents each instruction to decode through a valid/ready handshake.
- Handles branch/jump redirects, start, and halt-on-halt-word.

Parameters:
- ADDR_W, 8, PC / ROM address width.
- DATA_W, 16, instruction width.
- ROM_LAT, 1, ROM read latency in clock cycles: address sampled at a rising edge, data valid after ROM_LAT edges. Legal range 1..3.
- START_PC, 8'h00, PC loaded on reset and on restart.
- HALT_WORD, 16'h0000, instruction word that halts fetch once accepted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start/restart pulse, sampled in IDLE and HALT.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_q  in  DATA_W  ROM read data.
- instr  out  DATA_W  instruction to decode.
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  decode accepts when valid && ready at a rising edge.
- redirect  in  1  branch/jump taken.
- redirect_pc  in  ADDR_W  target address.
- halted  out  1  fetch stopped on HALT_WORD.
- retired_cnt  out  16  accepted-instruction count (see Optional Feature).

Behaviour:
- Reset values (asynchronous): state=IDLE, pc=START_PC, rom_addr=START_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, retired_cnt=0, wait counter=0.
- rom_addr always equals pc, registered. It changes only at a rising edge and is stable for the full cycle before the ROM samples it.
- IDLE:
  - run=1 -> WAIT, wait counter=0.
  - Otherwise stay.
- WAIT:
  - Counts ROM_LAT cycles after rom_addr is stable.
  - When count reaches ROM_LAT: capture instr<=rom_q, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - Latency from entering WAIT to instr_valid=1 is ROM_LAT+1 cycles.
- HOLD:
  - instr, instr_pc and instr_valid are held stable while instr_ready=0.
  - On accept with instr!=HALT_WORD: pc<=pc+1, instr_valid<=0, go to WAIT.
  - On accept with instr==HALT_WORD: instr_valid<=0, halted<=1, go to HALT. pc is not advanced.
- HALT:
  - halted=1, instr_valid=0.
  - run=1 -> pc<=START_PC, halted<=0, go to WAIT.
- Redirect (highest priority, in WAIT or HOLD):
  - pc<=redirect_pc, wait counter<=0, instr_valid<=0, go to WAIT. Any in-flight or held instruction is discarded.
  - Redirect in the same cycle as an accept: the accept counts (retired, handshake complete), then the redirect applies; the halt check is skipped.
  - Redirect in IDLE or HALT: ignored.
- PC wrap: pc 8'hFF +1 = 8'h00, with no flag.
- Throughput: at most one instruction per ROM_LAT+2 cycles with instr_ready held at 1.
- Reset asserted mid-operation: immediate return to the reset values. No instruction is emitted until run is pulsed again.
- ROM data returned as X: instr is forwarded as-is. The block performs no checking.

Optional Feature:
- Macro: FETCH_RETIRE_CNT_EN.
- Defined:
  - retired_cnt increments by 1 on every accept, including the HALT_WORD accept.
  - Wraps 16'hFFFF -> 0.
  - Cleared by reset only.
- Undefined: retired_cnt is tied to 16'h0000 and no counter flops are inferred.

Decomposition:
- Shared package (proc_pkg) holds:
  - state encoding typedef: IDLE, WAIT, HOLD, HALT;
  - ADDR_W and DATA_W defaults;
  - HALT_WORD constant.
- One sub-module, fetch_pc, is natural: PC register with load (redirect/restart), increment, and wrap.
- The FSM and output registers stay in fetch_ctrl.

Test Plan:
- Basic fetch: ROM[0]=C30A, ROM[1]=C4F2, ROM[2]=0000, run pulse, instr_ready=1 -> instr sequence C30A@pc0, C4F2@pc1, 0000@pc2, then halted=1. First instr_valid 2 cycles after WAIT entry (ROM_LAT=1).
- Backpressure: instr_ready=0 for 5 cycles while holding C4F2@pc1 -> instr, instr_pc and instr_valid are stable for all 5 cycles, and rom_addr stays 8'h01 until the accept.
- Redirect: while holding C30A@pc0, assert redirect with redirect_pc=8'h0C -> instr_valid falls next cycle, rom_addr=8'h0C, next instr=990F@pc0C. A redirect coincident with accept of C30A also bumps retired_cnt (macro defined).
- Wrap: redirect to 8'hFF with ROM[FF]=1234 and ROM[00]=C30A, accept -> next instr_pc=8'h00, instr=C30A.
- Restart and reset: in HALT, pulse run -> fetch resumes at pc 0. Assert reset during WAIT at pc 8'h05 -> all outputs at their reset values immediately, and there is no instr_valid without a new run.
- Macro off: repeat the basic fetch -> retired_cnt stays 0 throughout. Macro on -> retired_cnt=3 after the halt.
